// File: rtl/bit_serial_mac_ctrl.sv
// Bit-serial unsigned multiply-accumulate sequencer: acc += a*b through one shared full adder.
// Build option SKIP_ZERO_EN: skip ADD passes for zero multiplier bits (data-dependent latency).

module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);
    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

// state | meaning
// IDLE  | waiting for start/clear
// ADD   | one full-adder bit per cycle over the whole accumulator
// SHIFT | advance to the next multiplier bit
// DONE  | one-cycle result pulse, acc already updated
module bit_serial_mac_ctrl #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 overflow
);
    localparam int CW = $clog2(ACC_WIDTH);
    localparam int PW = $clog2(WIDTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(ACC_WIDTH - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
    state_t state, state_next;

    logic [ACC_WIDTH-1:0] acc_sr;
    logic [ACC_WIDTH-1:0] addend_sr;
    logic [WIDTH-1:0]     mult_sr;
    logic [CW-1:0]        bit_cnt;
    logic [PW-1:0]        pass_cnt;
    logic                 carry_ff;
    logic                 fa_sum;
    logic                 fa_cout;

    full_adder fa (
        .a         (acc_sr[0]),
        .b         (addend_sr[0] & mult_sr[0]),
        .carry_in  (carry_ff),
        .sum       (fa_sum),
        .carry_out (fa_cout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
`ifdef SKIP_ZERO_EN
                    state_next = b[0] ? ADD : SHIFT;
`else
                    state_next = ADD;
`endif
                end
            end
            ADD: begin
                if (bit_cnt == BIT_LAST) state_next = SHIFT;
            end
            SHIFT: begin
                if (pass_cnt == PASS_LAST) state_next = DONE;
                else begin
`ifdef SKIP_ZERO_EN
                    // mult_sr[1] becomes mult_sr[0] after this cycle's shift
                    state_next = mult_sr[1] ? ADD : SHIFT;
`else
                    state_next = ADD;
`endif
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            overflow  <= 1'b0;
            acc_sr    <= '0;
            addend_sr <= '0;
            mult_sr   <= '0;
            bit_cnt   <= '0;
            pass_cnt  <= '0;
            carry_ff  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        acc      <= '0;
                        overflow <= 1'b0;
                    end
                    if (start) begin
                        acc_sr    <= clear ? '0 : acc;
                        addend_sr <= {{(ACC_WIDTH-WIDTH){1'b0}}, a};
                        mult_sr   <= b;
                        bit_cnt   <= '0;
                        pass_cnt  <= '0;
                        carry_ff  <= 1'b0;
                    end
                end
                ADD: begin
                    acc_sr    <= {fa_sum, acc_sr[ACC_WIDTH-1:1]};
                    addend_sr <= {addend_sr[0], addend_sr[ACC_WIDTH-1:1]};
                    carry_ff  <= fa_cout;
                    bit_cnt   <= bit_cnt + CW'(1);
                    // carry out of the MSB is dropped; only the sticky flag remembers it
                    if (bit_cnt == BIT_LAST && fa_cout) overflow <= 1'b1;
                end
                SHIFT: begin
                    addend_sr <= addend_sr << 1;
                    mult_sr   <= mult_sr >> 1;
                    carry_ff  <= 1'b0;
                    bit_cnt   <= '0;
                    pass_cnt  <= pass_cnt + PW'(1);
                    if (pass_cnt == PASS_LAST) acc <= acc_sr;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_mac_ctrl.sv
// Directed self-checking bench for bit_serial_mac_ctrl (WIDTH=4, ACC_WIDTH=12).
// Expected latencies follow SKIP_ZERO_EN when the bench is built with that macro.
`timescale 1ns/1ps

module tb_bit_serial_mac_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  a = '0;
    logic [3:0]  b = '0;
    logic        busy;
    logic        done;
    logic [11:0] acc;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    bit_serial_mac_ctrl #(.WIDTH(4), .ACC_WIDTH(12)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .clear    (clear),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .acc      (acc),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // cycles from the accept edge up to and including the done cycle
    function automatic int exp_lat(input logic [3:0] bv);
`ifdef SKIP_ZERO_EN
        int pc;
        pc = 0;
        for (int i = 0; i < 4; i++) pc += int'(bv[i]);
        return pc * 12 + 4 + 1;
`else
        return 4 * (12 + 1) + 1;
`endif
    endfunction

    // Issues one op and returns in the first IDLE cycle after done.
    // ps/pc: cycle index at which to poke start / clear while busy (0 = never).
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input bit clr,
                          input int ps, input int pc,
                          output int lat, output bit to, output bit busy_ok);
        a = av; b = bv; start = 1'b1; clear = clr;
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0;
        lat = 1; to = 1'b0; busy_ok = 1'b1;
        while (done !== 1'b1) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            start = (lat == ps);
            clear = (lat == pc);
            if (lat == ps) begin a = 4'd7; b = 4'd7; end
            if (lat >= 200) begin to = 1'b1; break; end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0; clear = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] outs;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        outs = {busy, done, overflow, |acc};
        checks++;
        if (outs !== 4'b0000) begin
            errors++; $display("FAIL reset_idle: busy/done/ovf/acc!=0 = %b expected 0000", outs);
        end
        a = 4'd3; b = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_before_abort: got %b expected 1", busy);
        end
        #2 reset = 1'b1;
        #1;
        outs = {busy, done, overflow, |acc};
        checks++;
        if (outs !== 4'b0000) begin
            errors++; $display("FAIL reset_mid_add: outputs %b expected 0000", outs);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        outs = {busy, done, overflow, |acc};
        checks++;
        if (outs !== 4'b0000) begin
            errors++; $display("FAIL after_abort_idle: outputs %b expected 0000", outs);
        end
    endtask

    task automatic test_basic();
        int lat; bit to, bok;
        do_clear();
        run_op(4'd3, 4'd5, 1'b0, 0, 0, lat, to, bok);
        checks++;
        if (to || lat != exp_lat(4'd5)) begin
            errors++; $display("FAIL basic_latency: got %0d (timeout=%0b) expected %0d", lat, to, exp_lat(4'd5));
        end
        checks++;
        if (acc !== 12'd15 || overflow !== 1'b0) begin
            errors++; $display("FAIL basic_acc: got %0d ovf %b expected 15 ovf 0", acc, overflow);
        end
        checks++;
        if (bok !== 1'b1) begin
            errors++; $display("FAIL basic_busy: busy dropped during op, got %b expected 1", bok);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_pulse: done %b busy %b after op, expected 0 0", done, busy);
        end
    endtask

    task automatic test_overflow();
        int lat; bit to, bok; int badlat;
        do_clear();
        badlat = 0;
        for (int i = 0; i < 18; i++) begin
            run_op(4'd15, 4'd15, 1'b0, 0, 0, lat, to, bok);
            if (to || lat != exp_lat(4'd15) || !bok) badlat++;
        end
        checks++;
        if (badlat != 0) begin
            errors++; $display("FAIL b2b_timing: %0d ops with wrong latency/busy, expected 0", badlat);
        end
        checks++;
        if (acc !== 12'd4050 || overflow !== 1'b0) begin
            errors++; $display("FAIL b2b_18: got %0d ovf %b expected 4050 ovf 0", acc, overflow);
        end
        run_op(4'd15, 4'd15, 1'b0, 0, 0, lat, to, bok);
        checks++;
        if (acc !== 12'd179 || overflow !== 1'b1) begin
            errors++; $display("FAIL wrap_19: got %0d ovf %b expected 179 ovf 1", acc, overflow);
        end
        run_op(4'd1, 4'd1, 1'b0, 0, 0, lat, to, bok);
        checks++;
        if (to || lat != exp_lat(4'd1)) begin
            errors++; $display("FAIL one_latency: got %0d expected %0d", lat, exp_lat(4'd1));
        end
        checks++;
        if (acc !== 12'd180 || overflow !== 1'b1) begin
            errors++; $display("FAIL sticky_ovf: got %0d ovf %b expected 180 ovf 1", acc, overflow);
        end
    endtask

    task automatic test_start_clear();
        int lat; bit to, bok;
        // acc=180, overflow=1 left by the previous test
        run_op(4'd2, 4'd3, 1'b1, 0, 0, lat, to, bok);
        checks++;
        if (acc !== 12'd6 || overflow !== 1'b0) begin
            errors++; $display("FAIL start_clear_ovf: got %0d ovf %b expected 6 ovf 0", acc, overflow);
        end
        do_clear();
        run_op(4'd10, 4'd10, 1'b0, 0, 0, lat, to, bok);
        checks++;
        if (acc !== 12'd100) begin
            errors++; $display("FAIL setup_100: got %0d expected 100", acc);
        end
        run_op(4'd2, 4'd3, 1'b1, 0, 0, lat, to, bok);
        checks++;
        if (acc !== 12'd6 || overflow !== 1'b0) begin
            errors++; $display("FAIL start_clear_100: got %0d ovf %b expected 6 ovf 0", acc, overflow);
        end
    endtask

    task automatic test_busy_ignore();
        int lat; bit to, bok;
        do_clear();
        run_op(4'd10, 4'd10, 1'b0, 0, 0, lat, to, bok);
        run_op(4'd2, 4'd3, 1'b0, 10, 20, lat, to, bok);
        checks++;
        if (to || lat != exp_lat(4'd3)) begin
            errors++; $display("FAIL ignore_latency: got %0d expected %0d", lat, exp_lat(4'd3));
        end
        checks++;
        if (acc !== 12'd106 || overflow !== 1'b0) begin
            errors++; $display("FAIL ignore_acc: got %0d ovf %b expected 106 ovf 0", acc, overflow);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || acc !== 12'd106) begin
            errors++; $display("FAIL ignore_no_restart: busy %b acc %0d expected 0 106", busy, acc);
        end
    endtask

    task automatic test_skip_zero();
        int lat; bit to, bok;
        do_clear();
        run_op(4'd10, 4'd10, 1'b0, 0, 0, lat, to, bok);
        run_op(4'd9, 4'd0, 1'b0, 0, 0, lat, to, bok);
        checks++;
        if (to || lat != exp_lat(4'd0)) begin
            errors++; $display("FAIL zero_b_latency: got %0d expected %0d", lat, exp_lat(4'd0));
        end
        checks++;
        if (acc !== 12'd100) begin
            errors++; $display("FAIL zero_b_acc: got %0d expected 100", acc);
        end
        run_op(4'd9, 4'd5, 1'b0, 0, 0, lat, to, bok);
        checks++;
        if (to || lat != exp_lat(4'd5)) begin
            errors++; $display("FAIL b5_latency: got %0d expected %0d", lat, exp_lat(4'd5));
        end
        checks++;
        if (acc !== 12'd145 || overflow !== 1'b0) begin
            errors++; $display("FAIL b5_acc: got %0d ovf %b expected 145 ovf 0", acc, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_start_clear();
        test_busy_ignore();
        test_skip_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
